// File: rtl/counter_pkg.sv
// Shared definitions for the mod-N counter scheduler: FSM states,
// requester side encoding and default sizing constants.
package counter_pkg;

  // Default sizing of the counter datapath and request step counts.
  localparam int unsigned MODULUS_DEF = 6;
  localparam int unsigned CW_DEF      = 3;
  localparam int unsigned SW_DEF      = 3;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Requester side; the value doubles as the counter direction bit.
  typedef enum logic {
    SIDE_DN = 1'b0,
    SIDE_UP = 1'b1
  } side_e;

endpackage : counter_pkg

// File: rtl/modn_step.sv
// Modulus-N up/down step counter. One step per enabled cycle in the
// direction given by dir (1 = up); wrap pulses with the wrapping update.
module modn_step #(
  parameter int unsigned MODULUS = 6,
  parameter int unsigned CW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] MAXV = CW'(MODULUS - 1);

  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;

  // Next count and wrap flag for one step in the requested direction.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (en) begin
      if (dir) begin
        if (count_q == MAXV) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAXV;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    end
  end

  // Count and wrap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule : modn_step

// File: rtl/count_sched.sv
// Round-robin scheduler granting N-step moves of a shared mod-N counter
// to an up requester and a down requester, one move at a time.
module count_sched
  import counter_pkg::*;
#(
  parameter int unsigned MODULUS = MODULUS_DEF,
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned SW      = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_up,
  input  logic [SW-1:0] steps_up,
  input  logic          req_dn,
  input  logic [SW-1:0] steps_dn,
  output logic          gnt_up,
  output logic          gnt_dn,
  output logic          done,
  output logic          busy,
  output logic          w,
  output logic          wrap,
  output logic [CW-1:0] counter
);

  state_e        state_q, state_d;
  side_e         last_q, last_d;
  logic [SW-1:0] remaining_q, remaining_d;
  logic          w_q, w_d;
  logic          gnt_up_q, gnt_up_d;
  logic          gnt_dn_q, gnt_dn_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          take_up, take_dn;
  logic          step_en;

  // Arbitration: a lone request wins; on a tie the side not served last wins.
  always_comb begin
    take_up = 1'b0;
    take_dn = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req_up && (!req_dn || last_q == SIDE_DN)) begin
        take_up = 1'b1;
      end else if (req_dn) begin
        take_dn = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-step grant skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_up) begin
          state_d = (steps_up == '0) ? ST_DONE : ST_RUN;
        end else if (take_dn) begin
          state_d = (steps_dn == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (remaining_q == SW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; done/busy are decoded from the next
  // state so that they come straight out of flops in the cycle they apply.
  always_comb begin
    remaining_d = remaining_q;
    w_d         = w_q;
    last_d      = last_q;
    gnt_up_d    = take_up;
    gnt_dn_d    = take_dn;
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    step_en     = (state_q == ST_RUN);
    if (take_up) begin
      remaining_d = steps_up;
      w_d         = 1'b1;
      last_d      = SIDE_UP;
    end else if (take_dn) begin
      remaining_d = steps_dn;
      w_d         = 1'b0;
      last_d      = SIDE_DN;
    end else if (step_en) begin
      remaining_d = remaining_q - SW'(1);
    end
  end

  // Grant, completion, direction and round-robin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      w_q         <= 1'b0;
      last_q      <= SIDE_DN;
      gnt_up_q    <= 1'b0;
      gnt_dn_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      w_q         <= w_d;
      last_q      <= last_d;
      gnt_up_q    <= gnt_up_d;
      gnt_dn_q    <= gnt_dn_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  modn_step #(
    .MODULUS (MODULUS),
    .CW      (CW)
  ) u_step (
    .clk   (clk),
    .rst   (rst),
    .en    (step_en),
    .dir   (w_q),
    .count (counter),
    .wrap  (wrap)
  );

  assign gnt_up = gnt_up_q;
  assign gnt_dn = gnt_dn_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign w      = w_q;

endmodule : count_sched

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: inputs change #1 after a rising edge and
// outputs are checked in that same window, one clock cycle per tick.
module tb_count_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_up, req_dn;
  logic [2:0] steps_up, steps_dn;
  logic       gnt_up, gnt_dn, done, busy, w, wrap;
  logic [2:0] counter;

  int total = 0;
  int bad   = 0;
  int wraps;

  always #5 clk = ~clk;

  count_sched #(.MODULUS(6), .CW(3), .SW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_up   (req_up),
    .steps_up (steps_up),
    .req_dn   (req_dn),
    .steps_dn (steps_dn),
    .gnt_up   (gnt_up),
    .gnt_dn   (gnt_dn),
    .done     (done),
    .busy     (busy),
    .w        (w),
    .wrap     (wrap),
    .counter  (counter)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // gnt_up, gnt_dn, done, busy, counter in one go
  task automatic chk5(input string tag, input logic gu, input logic gd,
                      input logic dn, input logic bz, input logic [2:0] c);
    check({tag, ".gnt_up"}, 32'(gnt_up), 32'(gu));
    check({tag, ".gnt_dn"}, 32'(gnt_dn), 32'(gd));
    check({tag, ".done"},   32'(done),   32'(dn));
    check({tag, ".busy"},   32'(busy),   32'(bz));
    check({tag, ".counter"}, 32'(counter), 32'(c));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_up = 1'b0; req_dn = 1'b0; steps_up = '0; steps_dn = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk5("rst", 0, 0, 0, 0, 3'd0);
    check("rst.w", 32'(w), 0);
    check("rst.wrap", 32'(wrap), 0);

    // 3 up steps from 0; steps change after grant must be ignored
    req_up = 1'b1; steps_up = 3'd3;
    tick();
    chk5("up3.k1", 1, 0, 0, 1, 3'd0);
    check("up3.w", 32'(w), 1);
    req_up = 1'b0; steps_up = 3'd6;
    tick(); chk5("up3.k2", 0, 0, 0, 1, 3'd1);
    tick(); chk5("up3.k3", 0, 0, 0, 1, 3'd2);
    tick(); chk5("up3.k4", 0, 0, 1, 1, 3'd3);
    tick(); chk5("up3.k5", 0, 0, 0, 0, 3'd3);
    check("up3.w_hold", 32'(w), 1);

    // 2 down steps from 0: 5 then 4, wrap on 0->5
    do_reset();
    check("rst2.counter", 32'(counter), 0);
    req_dn = 1'b1; steps_dn = 3'd2;
    tick();
    chk5("dn2.k1", 0, 1, 0, 1, 3'd0);
    check("dn2.w", 32'(w), 0);
    req_dn = 1'b0;
    tick(); chk5("dn2.k2", 0, 0, 0, 1, 3'd5);
    check("dn2.wrap1", 32'(wrap), 1);
    tick(); chk5("dn2.k3", 0, 0, 1, 1, 3'd4);
    check("dn2.wrap0", 32'(wrap), 0);
    tick(); chk5("dn2.k4", 0, 0, 0, 0, 3'd4);

    // Tie with steps 1 each: up, dn, up after reset
    do_reset();
    req_up = 1'b1; req_dn = 1'b1; steps_up = 3'd1; steps_dn = 3'd1;
    tick(); chk5("rr.g1", 1, 0, 0, 1, 3'd0);
    tick(); chk5("rr.d1", 0, 0, 1, 1, 3'd1);
    tick(); chk5("rr.i1", 0, 0, 0, 0, 3'd1);
    tick(); chk5("rr.g2", 0, 1, 0, 1, 3'd1);
    check("rr.w2", 32'(w), 0);
    tick(); chk5("rr.d2", 0, 0, 1, 1, 3'd0);
    tick(); chk5("rr.i2", 0, 0, 0, 0, 3'd0);
    tick(); chk5("rr.g3", 1, 0, 0, 1, 3'd0);
    req_up = 1'b0; req_dn = 1'b0;
    tick(); chk5("rr.d3", 0, 0, 1, 1, 3'd1);
    tick();

    // Zero-step grant: grant and done together, counter untouched
    req_up = 1'b1; steps_up = 3'd0;
    tick(); chk5("z.k1", 1, 0, 1, 1, 3'd1);
    req_up = 1'b0;
    tick(); chk5("z.k2", 0, 0, 0, 0, 3'd1);

    // 7 up from 0 ends at 1 with exactly one wrap
    do_reset();
    req_up = 1'b1; steps_up = 3'd7;
    tick(); chk5("up7.k1", 1, 0, 0, 1, 3'd0);
    req_up = 1'b0;
    wraps = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (wrap) wraps++;
    end
    chk5("up7.end", 0, 0, 1, 1, 3'd1);
    check("up7.wraps", 32'(wraps), 1);
    tick(); chk5("up7.idle", 0, 0, 0, 0, 3'd1);

    // Reset in the middle of a 5-step up move
    req_up = 1'b1; steps_up = 3'd5;
    tick(); chk5("ab.k1", 1, 0, 0, 1, 3'd1);
    req_up = 1'b0;
    tick(); chk5("ab.k2", 0, 0, 0, 1, 3'd2);
    tick(); chk5("ab.k3", 0, 0, 0, 1, 3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk5("ab.rst", 0, 0, 0, 0, 3'd0);
    check("ab.w", 32'(w), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk5("ab.quiet", 0, 0, 0, 0, 3'd0);
    end
    // Fresh request after abort; tie again goes to up since last reset to down
    req_up = 1'b1; req_dn = 1'b1; steps_up = 3'd2; steps_dn = 3'd4;
    tick(); chk5("fr.k1", 1, 0, 0, 1, 3'd0);
    req_up = 1'b0; req_dn = 1'b0;
    tick(); chk5("fr.k2", 0, 0, 0, 1, 3'd1);
    tick(); chk5("fr.k3", 0, 0, 1, 1, 3'd2);
    tick(); chk5("fr.k4", 0, 0, 0, 0, 3'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_count_sched

// File: doc/count_sched.md
# count_sched

Request scheduler for the shared mod-6 up/down counter. Two requesters (up side, down side) each ask for an N-step move of the counter; the block arbitrates round-robin, grants one request at a time, drives the direction bit `w` and step enable, and signals completion. It sits between the control logic and the counter datapath, which it owns as a sub-module.

## Interface
- `MODULUS`, 6, counter modulus; count range 0..MODULUS-1.
- `CW`, 3, counter width; must satisfy 2^CW >= MODULUS.
- `SW`, 3, step-count width of each request.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_up`  in  1  up requester wants the counter; hold until `gnt_up`.
- `steps_up`  in  SW  step count for the up request; sampled on grant.
- `req_dn`  in  1  down requester wants the counter; hold until `gnt_dn`.
- `steps_dn`  in  SW  step count for the down request; sampled on grant.
- `gnt_up` / `gnt_dn`  out  1  one-cycle grant pulse.
- `done`  out  1  one-cycle pulse; granted move complete.
- `busy`  out  1  high from grant through the done cycle.
- `w`  out  1  current direction: 1 = up, 0 = down.
- `wrap`  out  1  one-cycle pulse when the counter wraps (5→0 up, 0→5 down).
- `counter`  out  CW  current count.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: sample `req_up` and `req_dn`.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the side not served last.
  - `last` resets to down, so up wins the first tie.
- On a grant, register:
  - `w` = side (1 up, 0 down).
  - `remaining` = that side's steps.
  - `last` = that side.
  - `gnt_x` = 1 for exactly one cycle.
- Grant with `steps` ≠ 0: IDLE → RUN.
  - Each RUN cycle the counter advances one step in direction `w` and `remaining` decrements.
  - When `remaining` is 1 at the clock edge, the final step is taken and the state goes RUN → DONE.
- Grant with `steps` = 0: IDLE → DONE directly. The counter is untouched; `gnt_x` and `done` are high in the same cycle.
- DONE: `done` = 1 for one cycle, then → IDLE. Requests are not sampled in DONE.
- Counter arithmetic:
  - Up: count = (count == MODULUS-1) ? 0 : count+1.
  - Down: count = (count == 0) ? MODULUS-1 : count-1.
  - Steps ≥ MODULUS wrap naturally; e.g. 7 up from 0 ends at 1.
- `wrap` is registered alongside the count update that wraps.
- `w` holds its last value in IDLE; it changes only at a grant.
- A request dropped before its grant is simply not served; there is no error signal.
- `steps` changes after the grant are ignored.
- Reset (any state, including mid-RUN) aborts the move; no `done` is issued. Reset values:
  - state IDLE, `counter` 0, `w` 0, `last` down.
  - `gnt_up`, `gnt_dn`, `done`, `busy`, `wrap` all 0.

## Timing
- Requests sampled in IDLE cycle k → grant pulse in cycle k+1.
- Steps = N ≥ 1:
  - RUN occupies cycles k+1 .. k+N.
  - `counter` shows step i from cycle k+1+i.
  - `done` in cycle k+N+1; `counter` holds its final value there.
- Steps = 0: `gnt_x` and `done` both in cycle k+1.
- Next request sampled no earlier than cycle k+N+2, so minimum spacing between grants is N+2 cycles.
- `busy` is high in cycles k+1 .. k+N+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `counter_pkg`:
  - State encoding (IDLE/RUN/DONE localparams).
  - Default MODULUS/CW constants.
  - Side encoding (UP = 1, DN = 0).
- Sub-module `modn_step`:
  - Parameterized modulus counter with inputs `en` and `dir`; outputs `count` and `wrap`.
  - Synchronous active-high `rst`.
- `count_sched` contains the FSM, round-robin pointer, `remaining` register and grant/done registers, and instantiates one `modn_step`.

## Test plan
- Reset, then `req_up` with `steps_up`=3 → `gnt_up` pulse; `counter` 1,2,3; `done` one cycle later; `busy` spans 4 cycles.
- From 0, `req_dn` with `steps_dn`=2 → `counter` 5 then 4; `wrap` pulses on the 0→5 step; `w`=0.
- `req_up` and `req_dn` held together with steps 1 each, repeated → grants alternate up, dn, up; first grant is up after reset.
- `steps_up`=0 → `gnt_up` and `done` in the same cycle; `counter` unchanged.
- `steps_up`=7 from 0 → final `counter`=1; exactly one `wrap` pulse.
- Assert `rst` in the middle of a 5-step up move → next cycle `counter`=0, state IDLE, no `done`; a fresh request then completes normally.
